multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM for the MIPS-style datapath. It supersedes the single-cycle combinational decoder and sequences each instruction through fetch, decode, execute, memory and write-back states. It also handshakes with data memory, bounds memory waits with a timeout, and reports halt conditions. It sits between the instruction register/PC logic and the register file, ALU and memory enables.

## Interface
- `ALU_FUNC_W`, default 4: width of `ALU_func`; must be ≥ 3.
- `MEM_TIMEOUT`, default 15: maximum cycles spent in MEM waiting for `Mem_Ack`; 0 disables the timeout.
- `Clk`, in, 1: single clock; all state changes on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Instr`, in, 32: instruction word from instruction memory.
- `Instr_Valid`, in, 1: `Instr` is valid this cycle.
- `Zero`, in, 1: ALU zero flag; sampled in EXEC.
- `Mem_Ack`, in, 1: data memory has completed the request.
- `IR_LdEn`, out, 1: load the instruction register.
- `PC_sel`, out, 2: PC source; 0 = PC+4, 1 = branch target, 2 = jump target.
- `PC_LdEn`, out, 1: update the PC.
- `RF_WrEn`, out, 1: register file write.
- `RF_WrData_sel`, out, 1: write-back source; 0 = ALU, 1 = memory.
- `RF_B_sel`, out, 1: read port B address; 0 = rt, 1 = rd.
- `ALU_Bin_sel`, out, 1: ALU B operand; 0 = RF port B, 1 = sign-extended imm16.
- `ALU_func`, out, `ALU_FUNC_W`: ALU operation.
- `Mem_Req`, out, 1: data memory request.
- `Mem_WrEn`, out, 1: data memory write qualifier.
- `Halted`, out, 1: sticky halt flag.
- `Halt_Cause`, out, 2: 0 = none, 1 = memory timeout, 2 = illegal instruction.
- `State`, out, 3: current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH
  - `IR_LdEn = Instr_Valid`.
  - Stay in FETCH while `!Instr_Valid`.
  - On valid, capture opcode `Instr[31:26]`, func `Instr[5:0]` and the legality result, then go to DECODE.
- DECODE: all enables are 0. Next state is EXEC, or HALT if the instruction is illegal and the trap is enabled.
- Opcodes
  - 0x00 R-type: func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j.
  - `Instr == 0` is NOP: it passes through EXEC to WB with `RF_WrEn = 0`.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, zero-extended to `ALU_FUNC_W`. addi, lw and sw use ADD; beq uses SUB.
- EXEC
  - `ALU_func` is driven per opcode.
  - `ALU_Bin_sel = 1` for addi, lw and sw.
  - `RF_B_sel = 1` for sw.
  - R-type and addi go to WB; lw and sw go to MEM.
  - beq: `PC_LdEn = 1`, `PC_sel = Zero ? 1 : 0`, then FETCH.
  - j: `PC_LdEn = 1`, `PC_sel = 2`, then FETCH.
- MEM
  - `Mem_Req = 1`; `Mem_WrEn = 1` for sw; `ALU_func = ADD` is held.
  - On `Mem_Ack`: lw goes to WB; sw asserts `PC_LdEn` (PC+4) and goes to FETCH.
  - The wait counter increments each cycle without ack. When it reaches `MEM_TIMEOUT`, go to HALT with cause 1.
- WB
  - `RF_WrEn = 1`, except for NOP.
  - `RF_WrData_sel = 1` for lw.
  - `PC_LdEn = 1`, `PC_sel = 0`, then FETCH.
- HALT
  - All enables are 0.
  - `Halted = 1`; `Halt_Cause` is held.
  - Only `Reset_n` exits HALT.

## Timing
- Reset (async assert, sync release behaviour by design)
  - State = FETCH; stored opcode/func = 0; wait counter = 0; `Halted = 0`; `Halt_Cause = 0`.
  - All outputs are 0 while `Reset_n = 0`.
- Outputs
  - All outputs are combinational from the registered state and stored fields.
  - Exception: `IR_LdEn` also depends on `Instr_Valid`, and the MEM exit enables also depend on `Mem_Ack` (Mealy).
- Latency from the FETCH cycle with valid:
  - R-type/addi: 4 cycles.
  - beq/j: 3 cycles.
  - sw: 4 + w cycles.
  - lw: 5 + w cycles.
  - w is the number of MEM cycles without ack.
- `Mem_Ack` in the same cycle that the counter reaches `MEM_TIMEOUT`: the ack wins and there is no halt.
- The wait counter clears on MEM entry and exit. Its width is `$clog2(MEM_TIMEOUT+1)`, minimum 1.
- Reset mid-MEM drops `Mem_Req` immediately; no write completes.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an unknown opcode, or an unknown func with opcode 0x00 (other than `Instr == 0`), goes DECODE → HALT with `Halt_Cause = 2`.
- Not defined: illegal instructions execute as NOP (EXEC → WB with no write, PC+4), and `Halt_Cause = 2` is never produced.

## Structure
- Package `ctrl_pkg` holds:
  - the state encoding;
  - the opcode and func constants;
  - the ALU code constants;
  - the `PC_sel` and `Halt_Cause` encodings.
- Sub-module `instr_classify`: combinational opcode/func → class (RTYPE, ADDI, LW, SW, BEQ, J, NOP, ILLEGAL) plus ALU code. The FSM and the counter stay in the top module.

## Test plan
- add (`Instr = 0x00430820`), valid in cycle 0: `IR_LdEn` in cycle 0, `ALU_func = 0` in cycle 2, `RF_WrEn = 1` and `PC_LdEn = 1` in cycle 3, FETCH in cycle 4.
- lw (opcode 0x23) with `Mem_Ack` arriving after 3 wait cycles: `Mem_Req` high for 4 cycles, `Mem_WrEn = 0`, WB asserts `RF_WrData_sel = 1`, `RF_WrEn = 1`.
- beq with `Zero = 1`, then with `Zero = 0`: EXEC gives `PC_sel = 1`, then `PC_sel = 0`; `PC_LdEn = 1` both times; no `RF_WrEn`.
- sw with no `Mem_Ack` and `MEM_TIMEOUT = 15`: after 15 MEM cycles, `Halted = 1`, `Halt_Cause = 1`, all enables 0 until `Reset_n` is pulsed low.
- Opcode 0x3F: with `CTRL_ILLEGAL_TRAP_EN`, HALT with cause 2 after DECODE; without it, no `RF_WrEn`, PC+4, FETCH after 4 cycles.
- `Reset_n` asserted low during MEM: outputs go to 0 asynchronously; after release, State = 0 and `Halted = 0`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcode/func
// fields, ALU operation codes, PC source select and halt cause values.
// Latency: n/a (constants only). Backpressure: n/a.
package ctrl_pkg;

   // FSM state encoding; State output exposes these values directly.
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd7;

   // Primary opcodes (Instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (Instr[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation codes, zero-extended to ALU_FUNC_W at the top level
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;

   // PC source select
   localparam logic [1:0] PC_SEL_PC4    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

   // Halt cause
   localparam logic [1:0] HALT_NONE        = 2'd0;
   localparam logic [1:0] HALT_MEM_TIMEOUT = 2'd1;
   localparam logic [1:0] HALT_ILLEGAL     = 2'd2;

   typedef enum logic [2:0] {
      CLS_RTYPE   = 3'd0,
      CLS_ADDI    = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_J       = 3'd5,
      CLS_NOP     = 3'd6,
      CLS_ILLEGAL = 3'd7
   } instr_class_t;

endpackage

// File: rtl/instr_classify.sv
// Instruction classifier: maps opcode/func to an instruction class and ALU code.
// Latency: purely combinational. Backpressure: none.
// Ports: opcode, func, instr_zero (whole word was 0) -> instr_class, alu_code.
module instr_classify
   import ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   func,
   input  logic         instr_zero,
   output instr_class_t instr_class,
   output logic [2:0]   alu_code
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      alu_code    = ALU_ADD;
      // The all-zero word is a NOP even though opcode 0 / func 0 is otherwise
      // not a supported R-type function.
      if (instr_zero) begin
         instr_class = CLS_NOP;
      end else begin
         case (opcode)
            OP_RTYPE: begin
               instr_class = CLS_RTYPE;
               case (func)
                  FN_ADD:  alu_code = ALU_ADD;
                  FN_SUB:  alu_code = ALU_SUB;
                  FN_AND:  alu_code = ALU_AND;
                  FN_OR:   alu_code = ALU_OR;
                  FN_SLT:  alu_code = ALU_SLT;
                  default: instr_class = CLS_ILLEGAL;
               endcase
            end
            OP_ADDI: instr_class = CLS_ADDI;
            OP_LW:   instr_class = CLS_LW;
            OP_SW:   instr_class = CLS_SW;
            OP_BEQ: begin
               instr_class = CLS_BEQ;
               alu_code    = ALU_SUB;
            end
            OP_J:    instr_class = CLS_J;
            default: instr_class = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB with halt on
// memory timeout (and on illegal instructions when CTRL_ILLEGAL_TRAP_EN is defined).
// Latency: R/addi 4, beq/j 3, sw 4+w, lw 5+w cycles; waits in FETCH on !Instr_Valid, in MEM on !Mem_Ack.
// Ports: Clk, Reset_n (async active-low); Instr/Instr_Valid/Zero/Mem_Ack in;
//        datapath enables/selects, Mem_Req/Mem_WrEn, Halted/Halt_Cause, State out.
// ALU_FUNC_W must be >= 3; MEM_TIMEOUT = 0 disables the memory timeout.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int ALU_FUNC_W  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [31:0]           Instr,
   input  logic                  Instr_Valid,
   input  logic                  Zero,
   input  logic                  Mem_Ack,
   output logic                  IR_LdEn,
   output logic [1:0]            PC_sel,
   output logic                  PC_LdEn,
   output logic                  RF_WrEn,
   output logic                  RF_WrData_sel,
   output logic                  RF_B_sel,
   output logic                  ALU_Bin_sel,
   output logic [ALU_FUNC_W-1:0] ALU_func,
   output logic                  Mem_Req,
   output logic                  Mem_WrEn,
   output logic                  Halted,
   output logic [1:0]            Halt_Cause,
   output logic [2:0]            State
);

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   // Value of the wait counter during the last MEM cycle allowed without ack.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [2:0]       state, state_nxt;
   logic [5:0]       opcode_q, func_q;
   logic             nop_q;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             halted_q;
   logic [1:0]       cause_q, cause_nxt;
   logic             capture;
   instr_class_t     cls;
   logic [2:0]       alu_code;

   // Classification runs on the captured fields, so every later state sees a
   // stable class without re-reading Instr.
   instr_classify u_classify (
      .opcode      (opcode_q),
      .func        (func_q),
      .instr_zero  (nop_q),
      .instr_class (cls),
      .alu_code    (alu_code)
   );

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      cause_nxt     = cause_q;
      capture       = 1'b0;
      IR_LdEn       = 1'b0;
      PC_sel        = PC_SEL_PC4;
      PC_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = '0;
      Mem_Req       = 1'b0;
      Mem_WrEn      = 1'b0;

      case (state)
         ST_FETCH: begin
            // Gated by Reset_n so the only input-driven output stays 0 in reset.
            IR_LdEn = Instr_Valid & Reset_n;
            if (Instr_Valid) begin
               capture   = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (TRAP_EN && cls == CLS_ILLEGAL) begin
               state_nxt = ST_HALT;
               cause_nxt = HALT_ILLEGAL;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ALU_func     = ALU_FUNC_W'(alu_code);
            wait_cnt_nxt = '0;
            case (cls)
               CLS_ADDI: begin
                  ALU_Bin_sel = 1'b1;
                  state_nxt   = ST_WB;
               end
               CLS_LW: begin
                  ALU_Bin_sel = 1'b1;
                  state_nxt   = ST_MEM;
               end
               CLS_SW: begin
                  ALU_Bin_sel = 1'b1;
                  RF_B_sel    = 1'b1;
                  state_nxt   = ST_MEM;
               end
               CLS_BEQ: begin
                  PC_LdEn   = 1'b1;
                  PC_sel    = Zero ? PC_SEL_BRANCH : PC_SEL_PC4;
                  state_nxt = ST_FETCH;
               end
               CLS_J: begin
                  PC_LdEn   = 1'b1;
                  PC_sel    = PC_SEL_JUMP;
                  state_nxt = ST_FETCH;
               end
               // R-type, NOP and (untrapped) illegal all retire through WB.
               default: state_nxt = ST_WB;
            endcase
         end
         ST_MEM: begin
            Mem_Req  = 1'b1;
            Mem_WrEn = (cls == CLS_SW);
            ALU_func = ALU_FUNC_W'(ALU_ADD);
            // Ack is checked first so an ack on the final allowed cycle wins.
            if (Mem_Ack) begin
               wait_cnt_nxt = '0;
               if (cls == CLS_SW) begin
                  PC_LdEn   = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_WB;
               end
            end else if (MEM_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
               wait_cnt_nxt = '0;
               state_nxt    = ST_HALT;
               cause_nxt    = HALT_MEM_TIMEOUT;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         ST_WB: begin
            RF_WrEn       = (cls == CLS_RTYPE) || (cls == CLS_ADDI) || (cls == CLS_LW);
            RF_WrData_sel = (cls == CLS_LW);
            PC_LdEn       = 1'b1;
            state_nxt     = ST_FETCH;
         end
         ST_HALT: state_nxt = ST_HALT;
         // Unused encodings recover to FETCH.
         default: state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_FETCH;
         opcode_q <= '0;
         func_q   <= '0;
         nop_q    <= 1'b0;
         wait_cnt <= '0;
         halted_q <= 1'b0;
         cause_q  <= HALT_NONE;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         cause_q  <= cause_nxt;
         halted_q <= halted_q | (state_nxt == ST_HALT);
         if (capture) begin
            opcode_q <= Instr[31:26];
            func_q   <= Instr[5:0];
            nop_q    <= (Instr == 32'h0);
         end
      end
   end

   assign Halted     = halted_q;
   assign Halt_Cause = cause_q;
   assign State      = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int FW  = 4;
   localparam int TMO = 15;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_ADDI = 5,
                  K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_NOP = 10, K_ILL = 11;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [31:0]   Instr = 32'h0;
   logic          Instr_Valid = 1'b0;
   logic          Zero = 1'b0;
   logic          Mem_Ack = 1'b0;
   logic          IR_LdEn, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
   logic          Mem_Req, Mem_WrEn, Halted;
   logic [1:0]    PC_sel, Halt_Cause;
   logic [FW-1:0] ALU_func;
   logic [2:0]    State;

   multicycle_control #(.ALU_FUNC_W(FW), .MEM_TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Instr_Valid(Instr_Valid),
      .Zero(Zero), .Mem_Ack(Mem_Ack), .IR_LdEn(IR_LdEn), .PC_sel(PC_sel),
      .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
      .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
      .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn), .Halted(Halted),
      .Halt_Cause(Halt_Cause), .State(State)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       ir;
      logic [1:0] pc_sel;
      logic       pc_ld;
      logic       rf_wr;
      logic       wd_sel;
      logic       b_sel;
      logic       bin_sel;
      logic [3:0] alu;
      logic       mreq;
      logic       mwr;
      logic       halted;
      logic [1:0] cause;
      logic [2:0] state;
   } obs_t;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] ins;
      logic        z;
      logic        ack;
      obs_t        e;
   } step_t;

   step_t plan_q[$];
   obs_t  log_q[$];
   int    checks = 0;
   int    errors = 0;

   // ---------------- behavioural model ----------------
   function automatic int kind_of(input logic [31:0] ins);
      if (ins == 32'h0) return K_NOP;
      case (ins[31:26])
         6'h00: case (ins[5:0])
                   6'h20: return K_ADD;
                   6'h22: return K_SUB;
                   6'h24: return K_AND;
                   6'h25: return K_OR;
                   6'h2A: return K_SLT;
                   default: return K_ILL;
                endcase
         6'h08: return K_ADDI;
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h04: return K_BEQ;
         6'h02: return K_J;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input int k);
      case (k)
         K_SUB, K_BEQ: return 4'd1;
         K_AND:        return 4'd2;
         K_OR:         return 4'd3;
         K_SLT:        return 4'd4;
         default:      return 4'd0;
      endcase
   endfunction

   function automatic logic rb();
      return ($urandom_range(0, 1) != 0);
   endfunction

   function automatic obs_t blank(input logic [2:0] st);
      obs_t o;
      o = '0;
      o.state = st;
      return o;
   endfunction

   task automatic push(input logic rst, input logic vld, input logic [31:0] ins,
                       input logic z, input logic ack, input obs_t e);
      step_t s;
      s.rst = rst; s.vld = vld; s.ins = ins; s.z = z; s.ack = ack; s.e = e;
      plan_q.push_back(s);
   endtask

   // A few HALT cycles with random inputs, then a reset pulse (outputs all 0).
   task automatic halt_tail(input logic [1:0] cause);
      obs_t o;
      o = blank(3'd7);
      o.halted = 1'b1;
      o.cause  = cause;
      for (int i = 0; i < 4; i++) push(1'b1, rb(), $urandom, rb(), rb(), o);
      push(1'b0, 1'b1, $urandom, rb(), rb(), blank(3'd0));
   endtask

   // mode: 0 = ack after w idle MEM cycles, 1 = never ack (timeout), 2 = reset after w MEM cycles
   task automatic plan_instr(input logic [31:0] ins, input int gap, input int w,
                             input int mode, input logic zb);
      int   k;
      obs_t o;
      k = kind_of(ins);
      for (int i = 0; i < gap; i++) push(1'b1, 1'b0, $urandom, rb(), rb(), blank(3'd0));
      o = blank(3'd0);
      o.ir = 1'b1;
      push(1'b1, 1'b1, ins, rb(), rb(), o);
      push(1'b1, rb(), $urandom, rb(), rb(), blank(3'd1));
      if (k == K_ILL && TRAP) begin
         halt_tail(2'd2);
         return;
      end
      o = blank(3'd2);
      o.alu     = alu_of(k);
      o.bin_sel = (k == K_ADDI || k == K_LW || k == K_SW);
      o.b_sel   = (k == K_SW);
      if (k == K_BEQ) begin
         o.pc_ld  = 1'b1;
         o.pc_sel = zb ? 2'd1 : 2'd0;
         push(1'b1, rb(), $urandom, zb, rb(), o);
         return;
      end
      if (k == K_J) begin
         o.pc_ld  = 1'b1;
         o.pc_sel = 2'd2;
         push(1'b1, rb(), $urandom, rb(), rb(), o);
         return;
      end
      push(1'b1, rb(), $urandom, rb(), rb(), o);
      if (k == K_LW || k == K_SW) begin
         o = blank(3'd3);
         o.mreq = 1'b1;
         o.mwr  = (k == K_SW);
         if (mode == 1) begin
            for (int i = 0; i < TMO; i++) push(1'b1, rb(), $urandom, rb(), 1'b0, o);
            halt_tail(2'd1);
            return;
         end
         for (int i = 0; i < w; i++) push(1'b1, rb(), $urandom, rb(), 1'b0, o);
         if (mode == 2) begin
            push(1'b0, rb(), $urandom, rb(), rb(), blank(3'd0));
            return;
         end
         o.pc_ld = (k == K_SW);
         push(1'b1, rb(), $urandom, rb(), 1'b1, o);
         if (k == K_SW) return;
      end
      o = blank(3'd4);
      o.rf_wr  = !(k == K_NOP || k == K_ILL);
      o.wd_sel = (k == K_LW);
      o.pc_ld  = 1'b1;
      push(1'b1, rb(), $urandom, rb(), rb(), o);
   endtask

   // ---------------- compare ----------------
   function automatic obs_t snap();
      obs_t o;
      o.ir = IR_LdEn; o.pc_sel = PC_sel; o.pc_ld = PC_LdEn; o.rf_wr = RF_WrEn;
      o.wd_sel = RF_WrData_sel; o.b_sel = RF_B_sel; o.bin_sel = ALU_Bin_sel;
      o.alu = ALU_func; o.mreq = Mem_Req; o.mwr = Mem_WrEn; o.halted = Halted;
      o.cause = Halt_Cause; o.state = State;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("ir=%0d pcs=%0d pcl=%0d rfw=%0d wds=%0d bsel=%0d bin=%0d alu=%0d mreq=%0d mwr=%0d hlt=%0d cause=%0d st=%0d",
                       o.ir, o.pc_sel, o.pc_ld, o.rf_wr, o.wd_sel, o.b_sel, o.bin_sel,
                       o.alu, o.mreq, o.mwr, o.halted, o.cause, o.state);
   endfunction

   task automatic run_plan();
      step_t s;
      obs_t  a;
      while (plan_q.size() > 0) begin
         s = plan_q.pop_front();
         @(posedge Clk);
         #1;
         Reset_n = s.rst; Instr_Valid = s.vld; Instr = s.ins; Zero = s.z; Mem_Ack = s.ack;
         @(negedge Clk);
         a = snap();
         log_q.push_back(a);
         checks++;
         if (a !== s.e) begin
            errors++;
            $display("FAIL cycle_check log %0d: got [%s] expected [%s]", log_q.size() - 1, fmt(a), fmt(s.e));
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int count_mreq(input int from);
      int n = 0;
      for (int i = from; i < log_q.size(); i++) n += int'(log_q[i].mreq);
      return n;
   endfunction

   function automatic int count_field_rfwr(input int from);
      int n = 0;
      for (int i = from; i < log_q.size(); i++) n += int'(log_q[i].rf_wr);
      return n;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fn_tab [5];
      logic [5:0]  op;
      logic [31:0] r;
      int          c;
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      r = $urandom;
      c = $urandom_range(0, 11);
      case (c)
         0, 1, 2, 3, 4: return {6'h00, r[25:6], fn_tab[c]};
         5:  return {6'h08, r[25:0]};
         6:  return {6'h23, r[25:0]};
         7:  return {6'h2B, r[25:0]};
         8:  return {6'h04, r[25:0]};
         9:  return {6'h02, r[25:0]};
         10: return 32'h0;
         default: begin
            if (rb()) begin
               op = 6'($urandom_range(0, 63));
               while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
                      op == 6'h23 || op == 6'h2B)
                  op = 6'($urandom_range(0, 63));
               return {op, r[25:0]};
            end
            return {6'h00, r[25:6], 6'h3F};
         end
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int base;
      int r;
      // reset state, with Instr_Valid high to show IR_LdEn is held low in reset
      push(1'b0, 1'b1, 32'h00430820, 1'b0, 1'b0, blank(3'd0));
      run_plan();
      chk("reset_state", int'(log_q[0].state), 0);
      chk("reset_ir", int'(log_q[0].ir), 0);

      // add
      base = log_q.size();
      plan_instr(32'h00430820, 0, 0, 0, 1'b0);
      plan_instr(32'h0, 0, 0, 0, 1'b0);
      run_plan();
      chk("add_ir_c0", int'(log_q[base].ir), 1);
      chk("add_exec_c2", int'(log_q[base + 2].state), 2);
      chk("add_alu_c2", int'(log_q[base + 2].alu), 0);
      chk("add_rfwr_c3", int'(log_q[base + 3].rf_wr), 1);
      chk("add_pcld_c3", int'(log_q[base + 3].pc_ld), 1);
      chk("add_fetch_c4", int'(log_q[base + 4].state), 0);

      // lw with 3 wait cycles
      base = log_q.size();
      plan_instr(32'h8C410004, 0, 3, 0, 1'b0);
      run_plan();
      chk("lw_mreq_cycles", count_mreq(base), 4);
      chk("lw_mwr", int'(log_q[base + 4].mwr), 0);
      chk("lw_wb_wdsel", int'(log_q[base + 7].wd_sel), 1);
      chk("lw_wb_rfwr", int'(log_q[base + 7].rf_wr), 1);

      // beq taken then not taken
      base = log_q.size();
      plan_instr(32'h10220003, 0, 0, 0, 1'b1);
      plan_instr(32'h10220003, 0, 0, 0, 1'b0);
      run_plan();
      chk("beq_taken_pcsel", int'(log_q[base + 2].pc_sel), 1);
      chk("beq_taken_pcld", int'(log_q[base + 2].pc_ld), 1);
      chk("beq_nt_pcsel", int'(log_q[base + 5].pc_sel), 0);
      chk("beq_nt_pcld", int'(log_q[base + 5].pc_ld), 1);
      chk("beq_no_rfwr", count_field_rfwr(base), 0);

      // sw that never gets an ack
      base = log_q.size();
      plan_instr(32'hAC410004, 0, 0, 1, 1'b0);
      run_plan();
      chk("sw_tmo_mreq_cycles", count_mreq(base), 15);
      chk("sw_tmo_halted", int'(log_q[base + 18].halted), 1);
      chk("sw_tmo_cause", int'(log_q[base + 18].cause), 1);
      chk("sw_tmo_post_reset_halted", int'(log_q[base + 22].halted), 0);

      // lw whose ack lands on the last allowed cycle
      base = log_q.size();
      plan_instr(32'h8C410004, 0, 14, 0, 1'b0);
      run_plan();
      chk("lw_late_ack_no_halt", int'(log_q[base + 18].state), 4);

      // opcode 0x3F
      base = log_q.size();
      plan_instr(32'hFC000000, 0, 0, 0, 1'b0);
      plan_instr(32'h0, 0, 0, 0, 1'b0);
      run_plan();
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("ill_halt_state", int'(log_q[base + 2].state), 7);
      chk("ill_halt_cause", int'(log_q[base + 2].cause), 2);
`else
      chk("ill_wb_state", int'(log_q[base + 3].state), 4);
      chk("ill_no_rfwr", int'(log_q[base + 3].rf_wr), 0);
      chk("ill_pc4", int'(log_q[base + 3].pc_ld), 1);
      chk("ill_fetch_c4", int'(log_q[base + 4].state), 0);
`endif

      // reset during MEM
      base = log_q.size();
      plan_instr(32'hAC410004, 0, 2, 2, 1'b0);
      plan_instr(32'h00430820, 0, 0, 0, 1'b0);
      run_plan();
      chk("rst_mem_mreq", int'(log_q[base + 5].mreq), 0);
      chk("rst_mem_mwr", int'(log_q[base + 5].mwr), 0);
      chk("rst_after_state", int'(log_q[base + 6].state), 0);
      chk("rst_after_halted", int'(log_q[base + 6].halted), 0);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 19);
         plan_instr(rand_instr(), $urandom_range(0, 3),
                    (r < 4) ? 14 : $urandom_range(0, 14),
                    (r == 19) ? 1 : ((r == 18) ? 2 : 0), rb());
         run_plan();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
